uart_rx_cfg: RTL

//  Runtime-configurable UART receiver: 5..MAX_DATA_W data bits, none/even/odd parity, 1 or 2 stop bits.
//  Per-word frame/parity/break status, sticky overrun, and a valid/ready receive FIFO.

---
 rtl/uart_pkg.sv | 48 ++++
 rtl/uart_rx_cfg_if.sv | 23 ++
 rtl/uart_rx_fifo.sv | 64 ++++++
 rtl/uart_rx_cfg.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the configurable UART receiver: parity modes, receive word, FSM states.
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
package uart_pkg;

    localparam int MAX_DATA_W = 9;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_EVEN     = 2'b01,
        PAR_ODD      = 2'b10,
        PAR_NONE_ALT = 2'b11
    } parity_e;

    typedef struct packed {
        logic                  brk;
        logic                  frame_err;
        logic                  par_err;
        logic [MAX_DATA_W-1:0] data;
    } rx_word_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } rx_state_e;

    // Out-of-range data widths fall back to the widest supported field.
    function automatic logic [3:0] eff_data_bits(input logic [3:0] bits);
        if (bits >= 4'd5 && bits <= 4'(MAX_DATA_W)) begin
            return bits;
        end
        return 4'(MAX_DATA_W);
    endfunction

    // Encoding 11 is an alias for "no parity".
    function automatic parity_e eff_parity(input logic [1:0] p);
        case (p)
            2'b01:   return PAR_EVEN;
            2'b10:   return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Receive-word handshake between the UART receiver (master) and the register block (slave).
// Latency: none, wires only.
// Backpressure: consumer holds rx_ready_i low to stall; head word stays stable while rx_valid_o is high.
interface uart_rx_cfg_if;

    logic [uart_pkg::MAX_DATA_W-1:0] rx_data_o;     // head data, LSB-aligned
    logic                            rx_frame_err;  // head: a stop bit sampled 0
    logic                            rx_par_err;    // head: parity mismatch
    logic                            rx_break;      // head: whole frame low through first stop
    logic                            rx_valid_o;    // FIFO non-empty
    logic                            rx_ready_i;    // pop head when valid & ready

    modport master (
        output rx_data_o, rx_frame_err, rx_par_err, rx_break, rx_valid_o,
        input  rx_ready_i
    );

    modport slave (
        input  rx_data_o, rx_frame_err, rx_par_err, rx_break, rx_valid_o,
        output rx_ready_i
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO of rx_word_t; ports: i_push/i_push_dat/o_full in, o_pop_vld/i_pop_rdy/o_pop_dat/o_level out.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: push while full is dropped unless a pop happens the same cycle; head reads 0 when empty.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_push,
    input  rx_word_t                     i_push_dat,
    output logic                         o_full,
    output logic                         o_pop_vld,
    input  logic                         i_pop_rdy,
    output rx_word_t                     o_pop_dat,
    output logic [$clog2(DEPTH+1)-1:0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    rx_word_t          r_mem [DEPTH];
    logic [AW-1:0]     r_wr;
    logic [AW-1:0]     r_rd;
    logic [LW-1:0]     r_level;
    logic              w_pop;
    logic              w_push_ok;

    assign o_full    = (r_level == LW'(DEPTH));
    assign o_pop_vld = (r_level != '0);
    assign o_level   = r_level;
    assign w_pop     = o_pop_vld & i_pop_rdy;
    // When full, a same-cycle pop frees the slot the write pointer targets.
    assign w_push_ok = i_push & (~o_full | w_pop);
    assign o_pop_dat = o_pop_vld ? r_mem[r_rd] : '0;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr] <= i_push_dat;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (5..9 data bits, none/even/odd parity, 1/2 stop bits) with status FIFO.
// Ports: clk/reset, rx_din_i line, rx_en, baud_div + cfg_* (latched at start), rx_if word handshake,
// rx_level/rx_ing/rx_overrun status, err_clr_i.
// Latency: word pushed one clk after the final stop sample, rx_valid_o one clk after that.
// Backpressure: rx_ready_i low lets the FIFO fill; further words are dropped and rx_overrun set.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DIV_W       = 12
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              rx_din_i,
    input  logic                              rx_en,
    input  logic [DIV_W-1:0]                  baud_div,
    input  logic [3:0]                        cfg_data_bits,
    input  logic [1:0]                        cfg_parity,
    input  logic                              cfg_stop2,
    uart_rx_cfg_if.master                     rx_if,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   rx_level,
    output logic                              rx_ing,
    output logic                              rx_overrun,
    input  logic                              err_clr_i
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rxs_d;
    logic                   w_rxs;
    logic                   w_fall;

    rx_state_e              r_state;
    rx_state_e              w_state_nxt;

    logic [DIV_W-1:0]       r_div;
    logic [DIV_W-1:0]       r_timer;
    logic [DIV_W-1:0]       w_div_eff;
    logic [3:0]             r_nbits;
    logic [3:0]             r_bitcnt;
    parity_e                r_par;
    logic                   r_stop2;
    logic                   r_par_bit;
    logic                   r_stop1_bad;
    logic [MAX_DATA_W-1:0]  r_shift;
    logic [MAX_DATA_W-1:0]  w_data_aligned;

    logic                   w_half;
    logic                   w_full_tick;
    logic                   w_last_bit;
    logic                   w_timer_clr;
    logic                   w_start;
    logic                   w_smp_data;
    logic                   w_smp_par;
    logic                   w_smp_stop1;
    logic                   w_final;

    logic                   w_stop1_bad_now;
    logic                   w_par_x;
    rx_word_t               w_word;
    rx_word_t               r_word;
    logic                   r_push;

    rx_word_t               w_head;
    logic                   w_fifo_full;
    logic                   w_valid;
    logic                   w_pop;
    logic                   r_overrun;

    // Synchroniser presets to the idle-high level so reset never looks like a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync  <= '1;
            r_rxs_d <= 1'b1;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], rx_din_i};
            r_rxs_d <= w_rxs;
        end
    end

    assign w_rxs     = r_sync[SYNC_STAGES-1];
    assign w_fall    = r_rxs_d & ~w_rxs;
    assign w_div_eff = (baud_div < DIV_W'(4)) ? DIV_W'(4) : baud_div;

    assign w_half      = (r_timer == (r_div >> 1));
    assign w_full_tick = (r_timer == (r_div - DIV_W'(1)));
    assign w_last_bit  = (r_bitcnt == (r_nbits - 4'd1));
    assign w_timer_clr = (r_state == ST_IDLE) | ((r_state == ST_START) ? w_half : w_full_tick);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (!rx_en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (w_fall) w_state_nxt = ST_START;
                ST_START:  if (w_half) w_state_nxt = w_rxs ? ST_IDLE : ST_DATA;
                ST_DATA:   if (w_full_tick && w_last_bit)
                               w_state_nxt = (r_par != PAR_NONE) ? ST_PARITY : ST_STOP1;
                ST_PARITY: if (w_full_tick) w_state_nxt = ST_STOP1;
                ST_STOP1:  if (w_full_tick) w_state_nxt = r_stop2 ? ST_STOP2 : ST_IDLE;
                ST_STOP2:  if (w_full_tick) w_state_nxt = ST_IDLE;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs / sample strobes ----------------
    always_comb begin
        rx_ing      = (r_state != ST_IDLE);
        w_start     = 1'b0;
        w_smp_data  = 1'b0;
        w_smp_par   = 1'b0;
        w_smp_stop1 = 1'b0;
        w_final     = 1'b0;
        case (r_state)
            ST_IDLE:   w_start    = rx_en & w_fall;
            ST_DATA:   w_smp_data = w_full_tick;
            ST_PARITY: w_smp_par  = w_full_tick;
            ST_STOP1: begin
                w_smp_stop1 = w_full_tick;
                w_final     = rx_en & w_full_tick & ~r_stop2;
            end
            ST_STOP2:  w_final    = rx_en & w_full_tick;
            default: ;
        endcase
    end

    // Data enters at the MSB, so after r_nbits shifts the word sits in the top bits.
    assign w_data_aligned  = r_shift >> (4'(MAX_DATA_W) - r_nbits);
    // On the final sample the stop-1 result is either live (1 stop bit) or captured earlier.
    assign w_stop1_bad_now = (r_state == ST_STOP1) ? ~w_rxs : r_stop1_bad;
    assign w_par_x         = ^{r_shift, r_par_bit};

    always_comb begin
        w_word           = '0;
        w_word.data      = w_data_aligned;
        w_word.frame_err = w_stop1_bad_now | ((r_state == ST_STOP2) & ~w_rxs);
        w_word.par_err   = ((r_par == PAR_EVEN) &  w_par_x) |
                           ((r_par == PAR_ODD)  & ~w_par_x);
        w_word.brk       = (r_shift == '0) & ~r_par_bit & w_stop1_bad_now;
    end

    // ---------------- Datapath: timer, shifter, config latch, push ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer     <= '0;
            r_div       <= '0;
            r_nbits     <= '0;
            r_par       <= PAR_NONE;
            r_stop2     <= 1'b0;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_par_bit   <= 1'b0;
            r_stop1_bad <= 1'b0;
            r_push      <= 1'b0;
            r_word      <= '0;
        end else begin
            r_timer <= w_timer_clr ? '0 : r_timer + DIV_W'(1);
            if (w_start) begin
                r_div       <= w_div_eff;
                r_nbits     <= eff_data_bits(cfg_data_bits);
                r_par       <= eff_parity(cfg_parity);
                r_stop2     <= cfg_stop2;
                r_bitcnt    <= '0;
                r_shift     <= '0;
                r_par_bit   <= 1'b0;
                r_stop1_bad <= 1'b0;
            end
            if (w_smp_data) begin
                r_shift  <= {w_rxs, r_shift[MAX_DATA_W-1:1]};
                r_bitcnt <= r_bitcnt + 4'd1;
            end
            if (w_smp_par) begin
                r_par_bit <= w_rxs;
            end
            if (w_smp_stop1) begin
                r_stop1_bad <= ~w_rxs;
            end
            r_push <= w_final;
            if (w_final) begin
                r_word <= w_word;
            end
        end
    end

    // ---------------- Receive FIFO ----------------
    uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (r_push),
        .i_push_dat (r_word),
        .o_full     (w_fifo_full),
        .o_pop_vld  (w_valid),
        .i_pop_rdy  (rx_if.rx_ready_i),
        .o_pop_dat  (w_head),
        .o_level    (rx_level)
    );

    assign w_pop              = w_valid & rx_if.rx_ready_i;
    assign rx_if.rx_valid_o   = w_valid;
    assign rx_if.rx_data_o    = w_head.data;
    assign rx_if.rx_frame_err = w_head.frame_err;
    assign rx_if.rx_par_err   = w_head.par_err;
    assign rx_if.rx_break     = w_head.brk;

    // Overrun is sticky; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overrun <= 1'b0;
        end else if (r_push & w_fifo_full & ~w_pop) begin
            r_overrun <= 1'b1;
        end else if (err_clr_i) begin
            r_overrun <= 1'b0;
        end
    end

    assign rx_overrun = r_overrun;

endmodule
